// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with valid/ready handshakes on both sides,
// first-word-fall-through read data, occupancy count, almost-full/empty flags
// and sticky overflow/underflow error flags.
//
// Parameters
//   DATA_W    data width (>=1)
//   DEPTH     entries, power of two (>=2)
//   AF_LEVEL  almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   wr_valid/wr_data/wr_ready   producer side handshake
//   rd_valid/rd_data/rd_ready   consumer side handshake (rd_data FWFT, 0 when empty)
//   count                   occupancy 0..DEPTH
//   almost_full/almost_empty    level flags
//   overflow/underflow      sticky error flags, cleared by clr_err
// ----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         ovf_q, ovf_d;
  logic                         udf_q, udf_d;
  logic                         wr_do, rd_do;

  // Handshake qualifiers come from the count register only, so there is
  // no combinational path from rd_ready to wr_ready or wr_valid to rd_valid.
  assign wr_ready = (count_q < CW'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign wr_do    = wr_valid & wr_ready;
  assign rd_do    = rd_ready & rd_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_do) wr_ptr_d = wr_ptr_q + AW'(1);  // natural wrap at DEPTH
    if (rd_do) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(wr_do) - CW'(rd_do);
    // Error event in the same cycle as clr_err wins.
    ovf_d    = (ovf_q & ~clr_err) | (wr_valid & ~wr_ready);
    udf_d    = (udf_q & ~clr_err) | (rd_ready & ~rd_valid);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_do) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data      = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst_n, wr_valid, rd_ready, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       wr_ready, rd_valid, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;
  int         n_chk = 0, n_err = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .count(count), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_valid = 1'b1; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    chk(tag, rd_data, exp);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 8'h99; rd_ready = 1'b0; clr_err = 1'b0;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    rst_n = 1'b1; wr_valid = 1'b0;
    step();
    chk("rst_drop_write", count, 0);

    // Fill and overflow
    wr(8'h11);
    chk("fwft_valid", rd_valid, 1);
    chk("fwft_data", rd_data, 8'h11);
    chk("fill1_count", count, 1);
    chk("fill1_ae", almost_empty, 1);
    wr(8'h22);
    chk("fill2_ae", almost_empty, 0);
    chk("fill2_af", almost_full, 0);
    wr(8'h33);
    chk("fill3_count", count, 3);
    chk("fill3_af", almost_full, 1);
    chk("fill3_wr_ready", wr_ready, 1);
    wr(8'h44);
    chk("fill4_count", count, 4);
    chk("fill4_wr_ready", wr_ready, 0);
    wr(8'h55);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    rd("rd0", 8'h11);
    rd("rd1", 8'h22);
    rd("rd2", 8'h33);
    rd("rd3", 8'h44);
    chk("drain_count", count, 0);
    chk("drain_valid", rd_valid, 0);
    chk("drain_data", rd_data, 0);
    chk("ovf_sticky", overflow, 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Wrap-around with simultaneous write/read at count=2
    wr(8'h60); wr(8'h61);
    for (int i = 0; i < 10; i++) begin
      e = (i == 0) ? 8'h60 : (i == 1) ? 8'h61 : 8'(8'h70 + i - 2);
      chk($sformatf("wrap_data%0d", i), rd_data, e);
      wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 8'(8'h70 + i);
      step();
      chk($sformatf("wrap_count%0d", i), count, 2);
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("wrap_ovf", overflow, 0);
    chk("wrap_udf", underflow, 0);

    // Full with simultaneous read: queue holds 78,79 -> fill to 4
    wr(8'h80); wr(8'h81);
    chk("full_count", count, 4);
    chk("full_head", rd_data, 8'h78);
    wr_valid = 1'b1; wr_data = 8'hAA; rd_ready = 1'b1;
    step();
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("fullrd_count", count, 3);
    chk("fullrd_ovf", overflow, 1);
    rd("fullrd0", 8'h79);
    rd("fullrd1", 8'h80);
    rd("fullrd2", 8'h81);
    chk("fullrd_empty", rd_valid, 0);
    chk("fullrd_noAA", count, 0);

    // Underflow and clear
    clr_err = 1'b1; step(); clr_err = 1'b0;
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("udf_flag", underflow, 1);
    chk("udf_count", count, 0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("udf_clr", underflow, 0);
    clr_err = 1'b1; rd_ready = 1'b1; step(); clr_err = 1'b0; rd_ready = 1'b0;
    chk("udf_clr_race", underflow, 1);

    // Reset mid-operation
    wr(8'h01); wr(8'h02); wr(8'h03);
    chk("mid_count", count, 3);
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 8'hEE;
    step();
    rst_n = 1'b1; wr_valid = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_udf", underflow, 0);
    wr(8'h5A);
    chk("mid_first", rd_data, 8'h5A);
    chk("mid_first_count", count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO that generalises the team's 4×8 buffer to arbitrary data width and power-of-two depth. It adds valid/ready handshakes on both sides, first-word-fall-through (FWFT) read data, an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits between a byte-stream producer on the TT input pins and a consumer on the output pins, in a single clock domain.

## Interface
- DATA_W, default 8: data width in bits, ≥1.
- DEPTH, default 4: number of entries; power of two, ≥2.
- AF_LEVEL, default DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, default 1: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- wr_valid  in  1  producer offers wr_data this cycle.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  FIFO can accept a write; equals (count < DEPTH).
- rd_valid  out  1  rd_data holds the head entry; equals (count != 0).
- rd_data  out  DATA_W  head entry (FWFT); driven 0 when rd_valid=0.
- rd_ready  in  1  consumer takes the head this cycle.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- overflow  out  1  sticky; set by a write attempted while full.
- underflow  out  1  sticky; set by a read attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

## Operation
- Storage: DEPTH×DATA_W register array. Memory contents are not reset. wr_ptr and rd_ptr are clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Write accept: wr_do = wr_valid & wr_ready. On wr_do, mem[wr_ptr] ← wr_data and wr_ptr increments.
- Read accept: rd_do = rd_ready & rd_valid. On rd_do, rd_ptr increments. rd_data is combinational: mem[rd_ptr] gated by rd_valid.
- Count update: count_next = count + wr_do − rd_do, evaluated in clog2(DEPTH)+1 bits. It never leaves 0..DEPTH.
- Simultaneous read and write:
  - 0 < count < DEPTH: both are accepted and count is unchanged.
  - count = DEPTH: only the read is accepted. wr_ready is 0, so the write is rejected and overflow is set.
  - count = 0: only the write is accepted. rd_valid is 0, so the read is rejected and underflow is set.
- wr_ready and rd_valid depend on the count register only. There is no combinational path from rd_ready to wr_ready or from wr_valid to rd_valid.
- Errors:
  - overflow ← 1 when wr_valid & !wr_ready.
  - underflow ← 1 when rd_ready & !rd_valid.
  - Rejected transfers leave pointers, count and memory unchanged.
  - clr_err clears both flags; an error event in the same cycle wins, and the flag is set.
- Reset (rst_n=0 at a rising edge) overrides all other inputs:
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Resulting outputs: wr_ready=1, rd_valid=0, rd_data=0, almost_full=0, almost_empty=1 (for AE_LEVEL≥0).
  - Reset mid-operation discards all stored entries; a write in the reset cycle is dropped.

## Timing
- Write-to-read latency is 1 cycle. For a write accepted at edge N into an empty FIFO, rd_valid=1 and rd_data=that word from edge N onward, visible in cycle N+1.
- A read accepted at edge N presents the next entry (or rd_valid=0) immediately after edge N.
- count, flags, wr_ready and rd_valid all update at the same edge as the transfer that changes them.
- Sticky flags set at the edge following the offending cycle.
- Throughput: one write and one read per cycle are sustained while 0 < count < DEPTH.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with wr_valid=1 → count=0, wr_ready=1, rd_valid=0, rd_data=0, almost_empty=1, overflow=0, underflow=0.
- Fill and overflow (DEPTH=4, AF_LEVEL=3): write 0x11,0x22,0x33,0x44, then 0x55 →
  - almost_full rises with count=3; wr_ready=0 at count=4.
  - 0x55 is dropped and overflow=1.
  - Reads return 0x11,0x22,0x33,0x44 in order with FWFT (rd_data=0x11 one cycle after the first write).
- Wrap-around: do 10 interleaved write/read pairs at count=2 with wr_valid=rd_ready=1 → count stays 2, output order matches input order across pointer wrap, no error flags.
- Full with simultaneous read: at count=4, assert wr_valid (0xAA) and rd_ready → the head is read, count=3, 0xAA is not stored, overflow=1.
- Empty, underflow and clear:
  - At count=0, assert rd_ready → underflow=1, count=0.
  - Assert clr_err → underflow=0.
  - Assert clr_err together with rd_ready at empty → underflow stays 1.
- Reset mid-operation: at count=3, pulse rst_n low for 1 cycle → count=0, rd_valid=0. The next write of 0x5A is read back as the first word.
